// File: rtl/ball_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ball_ctrl_pkg : shared playfield geometry and controller state encoding. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ball_ctrl_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BALL_SIZE = 2;
  localparam int PLAT_Y    = 110;
  localparam int PLATSIZE  = 16;
  localparam int PLATHALF  = PLATSIZE / 2;
  localparam int LIVES     = 3;

  typedef enum logic [2:0] {
    ST_SERVE  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_LOST   = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ball_ctrl_move_tick.sv
// ----------------------------------------------------------------------------
// move_tick : free-running divider, one-cycle tick at terminal count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module move_tick #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = run && !clr && (cnt == TC);

endmodule

`default_nettype wire

// File: rtl/ball_ctrl.sv
// ----------------------------------------------------------------------------
// ball_ctrl : paces ball moves, resolves wall/platform/brick bounces, lives. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ball_ctrl #(
  parameter int SCREEN_W  = ball_ctrl_pkg::SCREEN_W,
  parameter int SCREEN_H  = ball_ctrl_pkg::SCREEN_H,
  parameter int BALL_SIZE = ball_ctrl_pkg::BALL_SIZE,
  parameter int PLAT_Y    = ball_ctrl_pkg::PLAT_Y,
  parameter int PLAT_W    = ball_ctrl_pkg::PLATSIZE,
  parameter int TICK_DIV  = 833333,
  parameter int LIVES     = ball_ctrl_pkg::LIVES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] platx,
  input  logic       brick_hit,
  input  logic       brick_side,
  output logic       enable,
  output logic       x_du,
  output logic       y_du,
  output logic       plat_col,
  output logic       ball_lost,
  output logic [1:0] lives,
  output logic       game_over
);

  import ball_ctrl_pkg::*;

  localparam logic [10:0] SW11   = 11'(SCREEN_W);
  localparam logic [10:0] RWALL  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] TWRAP  = 11'(SCREEN_H + 16);
  localparam logic [10:0] LOSS_Y = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] BS11   = 11'(BALL_SIZE);
  localparam logic [10:0] BH11   = 11'(BALL_SIZE / 2);
  localparam logic [10:0] PY11   = 11'(PLAT_Y);
  localparam logic [10:0] PW11   = 11'(PLAT_W);
  localparam logic [10:0] PH11   = 11'(PLAT_W / 2);

  state_t      state, state_n;
  logic        enable_n, x_du_n, y_du_n, plat_col_n, ball_lost_n, game_over_n;
  logic [1:0]  lives_n;
  logic        hit_q, side_q, hit_now, side_now;
  logic        tick;
  logic [10:0] x11, y11, px11;
  logic        wall_l, wall_r, wall_t, plat_hit, plat_dir, loss;

  // CHECK also advances the divider so the move period is TICK_DIV+2 cycles.
  move_tick #(.TICK_DIV(TICK_DIV)) u_move_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state == ST_SERVE),
    .run    ((state == ST_WAIT) || (state == ST_CHECK)),
    .tick   (tick)
  );

  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign px11 = {1'b0, platx};

  assign wall_l   = (x11 == '0) || (x11 >= SW11);
  assign wall_r   = (x11 >= RWALL) && (x11 < SW11);
  assign wall_t   = (y11 == '0) || (y11 >= TWRAP);
  assign plat_hit = y_du && (y11 + BS11 >= PY11) && (y11 < PY11) &&
                    (x11 + BS11 > px11) && (x11 < px11 + PW11);
  assign plat_dir = (x11 + BH11 >= px11 + PH11);
  assign loss     = y_du && (y11 >= LOSS_Y) && !plat_hit;

  // A brick pulse landing in the CHECK cycle itself is honoured, not dropped.
  assign hit_now  = hit_q | brick_hit;
  assign side_now = brick_hit ? brick_side : side_q;

  always_comb begin
    state_n     = state;
    enable_n    = 1'b0;
    plat_col_n  = 1'b0;
    ball_lost_n = 1'b0;
    x_du_n      = x_du;
    y_du_n      = y_du;
    lives_n     = lives;
    game_over_n = game_over;
    case (state)
      ST_SERVE:  if (go) state_n = ST_WAIT;
      ST_WAIT: begin
        if (tick) begin
          state_n  = ST_MOVE;
          enable_n = 1'b1;
        end
      end
      ST_MOVE:   state_n = ST_SETTLE;
      ST_SETTLE: state_n = ST_CHECK;
      ST_CHECK: begin
        if (wall_l)                    x_du_n = 1'b1;
        else if (wall_r)               x_du_n = 1'b0;
        else if (plat_hit)             x_du_n = plat_dir;
        else if (hit_now && side_now)  x_du_n = ~x_du;
        if (wall_t)                    y_du_n = 1'b1;
        else if (plat_hit)             y_du_n = 1'b0;
        else if (hit_now && !side_now) y_du_n = ~y_du;
        plat_col_n = plat_hit;
        if (loss) begin
          state_n     = ST_LOST;
          ball_lost_n = 1'b1;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_LOST: begin
        lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
        x_du_n  = 1'b1;
        y_du_n  = 1'b0;
        if (lives_n == 2'd0) begin
          state_n     = ST_OVER;
          game_over_n = 1'b1;
        end else begin
          state_n = ST_SERVE;
        end
      end
      ST_OVER:   game_over_n = 1'b1;
      default:   state_n = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_SERVE;
      enable    <= 1'b0;
      x_du      <= 1'b1;
      y_du      <= 1'b0;
      plat_col  <= 1'b0;
      ball_lost <= 1'b0;
      lives     <= 2'(LIVES);
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      enable    <= enable_n;
      x_du      <= x_du_n;
      y_du      <= y_du_n;
      plat_col  <= plat_col_n;
      ball_lost <= ball_lost_n;
      lives     <= lives_n;
      game_over <= game_over_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= 1'b0;
      side_q <= 1'b0;
    end else if (state == ST_CHECK) begin
      hit_q  <= 1'b0;
    end else if (brick_hit && (state != ST_SERVE) && (state != ST_OVER)) begin
      hit_q  <= 1'b1;
      side_q <= brick_side;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ball_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_ctrl : randomized game-level checking of ball_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       resetn, go, brick_hit, brick_side;
  logic [9:0] x, y, platx;
  logic       enable, x_du, y_du, plat_col, ball_lost, game_over;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // game-level reference state
  bit m_xdu, m_ydu, pend_hit, pend_side;
  int m_lives, last_ref, exp_gap;

  ball_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .x          (x),
    .y          (y),
    .platx      (platx),
    .brick_hit  (brick_hit),
    .brick_side (brick_side),
    .enable     (enable),
    .x_du       (x_du),
    .y_du       (y_du),
    .plat_col   (plat_col),
    .ball_lost  (ball_lost),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"},    enable,    0);
    check({tag, "_x_du"},      x_du,      1);
    check({tag, "_y_du"},      y_du,      0);
    check({tag, "_plat_col"},  plat_col,  0);
    check({tag, "_ball_lost"}, ball_lost, 0);
    check({tag, "_lives"},     lives,     3);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic model_reset();
    m_xdu = 1; m_ydu = 0; m_lives = 3; pend_hit = 0; pend_side = 0;
  endtask

  task automatic idle(input string tag, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (enable !== 1'b0) seen = 1;
    end
    check(tag, seen, 0);
  endtask

  task automatic serve(input bit hold);
    go = 1'b1;
    last_ref = cyc;
    exp_gap  = 5;
    if (!hold) begin
      @(negedge clk);
      go = 1'b0;
    end
  endtask

  // One ball move: wait for the strobe, present the new position, then compare
  // the controller's reaction with the game rules evaluated on that position.
  task automatic do_move(input int nx, input int ny, input int npx, input bit inj, input bit side);
    bit ok = 0;
    bit wl, wr, wt, ph, ls, ex, ey;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (enable === 1'b1) ok = 1;
    end
    check("enable_seen", ok, 1);
    if (!ok) finish_run();
    check("move_gap", cyc - last_ref, exp_gap);
    last_ref = cyc;
    exp_gap  = 6;
    x = 10'(nx); y = 10'(ny); platx = 10'(npx);

    wl = (nx == 0) || (nx >= 160);
    wr = (nx >= 158) && (nx < 160);
    wt = (ny == 0) || (ny >= 136);
    ph = m_ydu && (ny + 2 >= 110) && (ny < 110) && (nx + 2 > npx) && (nx < npx + 16);
    ls = m_ydu && (ny >= 118) && !ph;
    // platform steering: ball centre at or right of platform centre goes right
    ex = wl ? 1'b1 : wr ? 1'b0 : ph ? (2 * nx + 2 >= 2 * npx + 16) :
         (pend_hit && pend_side) ? !m_xdu : m_xdu;
    ey = wt ? 1'b1 : ph ? 1'b0 : (pend_hit && !pend_side) ? !m_ydu : m_ydu;

    @(negedge clk);
    check("enable_width", enable, 0);
    repeat (2) @(negedge clk);
    check("plat_col", plat_col, ph);
    check("ball_lost", ball_lost, ls);
    if (!ls) begin
      check("x_du", x_du, ex);
      check("y_du", y_du, ey);
      m_xdu = ex; m_ydu = ey;
      brick_hit = inj; brick_side = side;
      @(negedge clk);
      brick_hit = 1'b0;
      check("plat_col_width", plat_col, 0);
      pend_hit = inj; pend_side = side;
    end else begin
      @(negedge clk);
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      check("ball_lost_width", ball_lost, 0);
      check("lives_after_loss", lives, m_lives);
      check("x_du_after_loss", x_du, 1);
      check("y_du_after_loss", y_du, 0);
      check("game_over", game_over, (m_lives == 0));
      m_xdu = 1; m_ydu = 0; pend_hit = 0;
    end
  endtask

  task automatic lose_ball();
    if (!m_ydu) do_move(80, 0, 70, 0, 0);
    do_move(100, 118, 0, 0, 0);
  endtask

  initial begin
    int edges [8] = '{0, 1, 157, 158, 159, 160, 1000, 1023};
    resetn = 1'b0; go = 1'b0; brick_hit = 1'b0; brick_side = 1'b0;
    x = 10'd80; y = 10'd60; platx = 10'd70;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    idle("no_enable_before_go", 10);

    // go held high through the whole run of normal play
    serve(1);
    do_move(80, 60, 70, 0, 0);
    do_move(80, 60, 70, 0, 0);
    do_move(158, 60, 70, 0, 0);
    do_move(0, 60, 70, 0, 0);
    do_move(158, 60, 70, 0, 0);
    do_move(1023, 60, 70, 0, 0);
    do_move(80, 0, 70, 0, 0);
    do_move(72, 108, 70, 0, 0);
    do_move(80, 0, 70, 0, 0);
    do_move(80, 108, 70, 0, 0);
    do_move(80, 50, 70, 1, 0);
    do_move(80, 50, 70, 1, 1);
    do_move(0, 50, 70, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int rx, ry, rp;
      rp = $urandom_range(0, 150);
      case ($urandom_range(0, 3))
        0:       rx = edges[$urandom_range(0, 7)];
        1:       rx = rp + $urandom_range(0, 19) - 2;
        default: rx = $urandom_range(1, 157);
      endcase
      if (rx < 0) rx = 0;
      case ($urandom_range(0, 9))
        0, 1, 2: ry = $urandom_range(105, 111);
        3:       ry = 0;
        4:       ry = $urandom_range(900, 1023);
        default: ry = $urandom_range(1, 117);
      endcase
      if (m_ydu && ry >= 118) ry = $urandom_range(1, 117);
      do_move(rx, ry, rp, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    go = 1'b0;
    lose_ball();
    idle("serve_waits_for_go", 20);
    serve(0);
    lose_ball();
    serve(0);
    lose_ball();
    go = 1'b1;
    idle("no_enable_after_over", 30);
    check("over_sticky", game_over, 1);
    check("over_lives", lives, 0);

    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset_from_over");
    @(negedge clk);
    go = 1'b0;
    resetn = 1'b1;
    model_reset();
    serve(0);
    do_move(158, 60, 70, 0, 0);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    @(negedge clk);
    resetn = 1'b1;
    idle("idle_after_reset", 12);

    finish_run();
  end

endmodule

`default_nettype wire

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Upstream controller for the ball position counter stage.
- Paces ball motion with a move tick and emits a one-cycle `enable` per move.
- After each move, evaluates wall, platform and brick collisions on the updated ball x/y, then drives the `x_du`/`y_du` direction bits and the `plat_col` pulse.
- Also handles serve, ball loss and the lives count.

Parameters:
- SCREEN_W, 160, playfield width in pixels
- SCREEN_H, 120, playfield height in pixels
- BALL_SIZE, 2, ball edge length in pixels
- PLAT_Y, 110, top row of platform
- PLAT_W, 16, platform width (equals PLATSIZE)
- TICK_DIV, 833333, clk cycles per move tick (60 Hz at 50 MHz)
- LIVES, 3, balls per game

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go  in  1  serve request (level; sampled in SERVE)
- x  in  10  ball x, integer part
- y  in  10  ball y, integer part
- platx  in  10  platform left x
- brick_hit  in  1  one-cycle pulse from brick collision logic
- brick_side  in  1  qualifies brick_hit: 1 = side hit, 0 = top/bottom hit
- enable  out  1  one-cycle move strobe to position counters
- x_du  out  1  1 = x increasing
- y_du  out  1  1 = y increasing (downward)
- plat_col  out  1  one-cycle platform-collision pulse
- ball_lost  out  1  one-cycle pulse; top level uses it to re-init ball position
- lives  out  2  remaining lives
- game_over  out  1  sticky; high when lives reach 0

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `resetn`; every register clears immediately on `resetn` low.
- Reset values:
  - state=SERVE, enable=0, x_du=1, y_du=0, plat_col=0, ball_lost=0, lives=LIVES, game_over=0
  - tick counter=0, hit latch=0
- States:
  - SERVE: wait for go=1 → WAIT, clear the tick counter.
  - WAIT: tick counter runs. On terminal count (TICK_DIV-1), wrap to 0 and → MOVE.
  - MOVE: enable=1 for exactly this cycle → SETTLE.
  - SETTLE: one cycle for the position counters to register the new x/y → CHECK.
  - CHECK: evaluate the rules below on current x, y and update directions, then → WAIT, or → LOST if the loss condition holds.
  - LOST: ball_lost=1 for one cycle, lives decrement. If the new value is 0 → OVER, else → SERVE with x_du=1, y_du=0.
  - OVER: game_over=1 and enable stays 0 until reset.
- Hit latch: set by brick_hit in any state except SERVE/OVER, together with the side bit. Cleared in CHECK. A later brick_hit overwrites the side bit.
- CHECK rules, all using 11-bit unsigned compares:
  - Left wall: x==0 or x>=SCREEN_W (underflow wrap) → x_du=1.
  - Right wall: x>=SCREEN_W-BALL_SIZE and x<SCREEN_W → x_du=0.
  - Top wall: y==0 or y>=SCREEN_H+16 (underflow wrap) → y_du=1.
  - Platform: y_du==1 and y+BALL_SIZE>=PLAT_Y and y<PLAT_Y and x+BALL_SIZE>platx and x<platx+PLAT_W → y_du=0, plat_col=1 for one cycle, x_du = (x+BALL_SIZE/2 >= platx+PLAT_W/2).
  - Brick (latched): side → invert x_du, else invert y_du.
  - Loss: y_du==1, y>=SCREEN_H-BALL_SIZE, no platform hit → LOST.
- Priority per axis: wall > platform > brick. On the same axis, a wall or platform assignment wins over a brick inversion. Inversions on different axes apply independently.
- plat_col, enable and ball_lost are registered outputs and never exceed one cycle.
- `go` held high across SERVE has no effect outside SERVE.
- lives saturates at 0.
- Move-to-move latency is exactly TICK_DIV+2 cycles when no loss occurs.

Decomposition:
- Shared macros file holds SCREEN_W, SCREEN_H, BALL_SIZE, PLAT_Y, PLATSIZE (=PLAT_W), PLATHALF, LIVES and the state encodings.
- One sub-module, move_tick: parameterised divider with inputs clk, resetn, clr, run and output tick (one-cycle pulse at terminal count).

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, then go=1 with x=80, y=60 → first enable 5 cycles after go. enable period is 6 cycles. x_du=1, y_du=0 unchanged.
2. x=158 at CHECK → x_du=0. x=0 → x_du=1. x=1023 (wrap) → x_du=1. plat_col stays 0.
3. y_du=1, y=108, platx=70: x=72 → y_du=0, plat_col pulse, x_du=0; x=80 → x_du=1.
4. brick_hit with side=0 during WAIT, y=50 → y_du inverts at next CHECK. brick_hit with side=1 coincident with x=0 → x_du=1 (wall wins).
5. y_du=1, y=118, platx=0, x=100 → ball_lost pulse, lives 3→2, state SERVE, enable stays 0 until go.
6. Three consecutive losses → lives=0, game_over=1, no enable afterwards. resetn low mid-WAIT → all outputs return to reset values asynchronously.
